// File: rtl/expr_frame_arbiter_pkg.sv
// Shared definitions for the expression-frame arbiter: FSM encoding,
// the recognizer idle byte and the default frame terminator.
package expr_frame_arbiter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_STREAM = 3'd2,
        ST_SETTLE = 3'd3,
        ST_REPORT = 3'd4
    } state_t;

    localparam logic [7:0] IDLE_BYTE = 8'h00;
    localparam logic [7:0] DEF_TERM  = 8'h3B;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/expr_frame_arbiter_rr_arb2.sv
// Two-way combinational round-robin arbiter: the requester that did not
// win last time has priority when both are requesting.
module expr_frame_arbiter_rr_arb2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       grant,
    output logic       any
);
    import expr_frame_arbiter_pkg::*;

    always_comb begin
        any   = |req;
        grant = (req == 2'b11) ? ~last_grant : req[1];
    end

endmodule

// File: rtl/expr_frame_arbiter.sv
// Shares one character-stream recognizer between two framed requesters.
// Optional idle timeout inside a frame is enabled with `define FRAME_TIMEOUT_EN.
module expr_frame_arbiter
    import expr_frame_arbiter_pkg::*;
#(
    parameter logic [7:0] TERM    = DEF_TERM,
    parameter int         TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       clr,
    input  logic [1:0] req,
    input  logic [7:0] ch0,
    input  logic [7:0] ch1,
    input  logic       vld0,
    input  logic       vld1,
    output logic       rdy0,
    output logic       rdy1,
    output logic [7:0] rec_in,
    output logic       rec_clr,
    input  logic       rec_out,
    output logic       done,
    output logic       done_id,
    output logic       result,
    output logic [7:0] frame_len,
    output logic       aborted
);

    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("TIMEOUT must be positive");
    end

    state_t     state_q, state_d;
    logic       grant_q, grant_d;
    logic       last_grant_q, last_grant_d;
    logic [7:0] cnt_q, cnt_d;
    logic       done_id_q, done_id_d;
    logic       result_q, result_d;
    logic [7:0] frame_len_q, frame_len_d;
    logic       arb_grant, arb_any;
    logic       vld_g;
    logic [7:0] ch_g;
    logic       cap, cap_abort;

`ifdef FRAME_TIMEOUT_EN
    localparam int IW = $clog2(TIMEOUT + 1);
    logic [IW-1:0] idle_q, idle_d;
    logic          aborted_q, aborted_d;
`endif

    expr_frame_arbiter_rr_arb2 u_arb (
        .req        (req),
        .last_grant (last_grant_q),
        .grant      (arb_grant),
        .any        (arb_any)
    );

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        done_id_d    = done_id_q;
        result_d     = result_q;
        frame_len_d  = frame_len_q;
        rdy0         = 1'b0;
        rdy1         = 1'b0;
        rec_in       = IDLE_BYTE;
        done         = 1'b0;
        cap          = 1'b0;
        cap_abort    = 1'b0;
        vld_g        = grant_q ? vld1 : vld0;
        ch_g         = grant_q ? ch1 : ch0;
`ifdef FRAME_TIMEOUT_EN
        idle_d       = idle_q;
        aborted_d    = aborted_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (arb_any) begin
                    grant_d = arb_grant;
                    state_d = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                cnt_d   = 8'd0;
                state_d = ST_STREAM;
`ifdef FRAME_TIMEOUT_EN
                idle_d  = '0;
`endif
            end
            ST_STREAM: begin
                rdy0 = ~grant_q;
                rdy1 = grant_q;
                if (vld_g) begin
                    rec_in = ch_g;
                    cnt_d  = sat_inc8(cnt_q);
                    if (ch_g == TERM) begin
                        state_d = ST_SETTLE;
                    end
`ifdef FRAME_TIMEOUT_EN
                    idle_d = '0;
                end else if (idle_q == IW'(TIMEOUT - 1)) begin
                    cap       = 1'b1;
                    cap_abort = 1'b1;
                    state_d   = ST_REPORT;
                end else begin
                    idle_d = idle_q + IW'(1);
`endif
                end
            end
            // rec_out now reflects TERM; results are latched on entry to REPORT
            ST_SETTLE: begin
                cap     = 1'b1;
                state_d = ST_REPORT;
            end
            ST_REPORT: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (cap) begin
            result_d     = cap_abort ? 1'b0 : rec_out;
            done_id_d    = grant_q;
            last_grant_d = grant_q;
            frame_len_d  = cap_abort ? cnt_q : cnt_d;
`ifdef FRAME_TIMEOUT_EN
            aborted_d    = cap_abort;
`endif
        end

        // nothing is accepted or reported while the block is held in reset
        if (clr) begin
            rdy0   = 1'b0;
            rdy1   = 1'b0;
            rec_in = IDLE_BYTE;
            done   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q      <= ST_IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            cnt_q        <= 8'd0;
            done_id_q    <= 1'b0;
            result_q     <= 1'b0;
            frame_len_q  <= 8'd0;
`ifdef FRAME_TIMEOUT_EN
            idle_q       <= '0;
            aborted_q    <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            done_id_q    <= done_id_d;
            result_q     <= result_d;
            frame_len_q  <= frame_len_d;
`ifdef FRAME_TIMEOUT_EN
            idle_q       <= idle_d;
            aborted_q    <= aborted_d;
`endif
        end
    end

    assign rec_clr   = clr | (state_q == ST_CLEAR);
    assign done_id   = done_id_q;
    assign result    = result_q;
    assign frame_len = frame_len_q;
`ifdef FRAME_TIMEOUT_EN
    assign aborted   = aborted_q;
`else
    assign aborted   = 1'b0;
`endif

endmodule
